// File: rtl/scroll_sequencer_pkg.sv
// scroll_pkg: shared types and glyph constants for the scroll sequencer.
// Glyphs are active-low segment patterns ordered {g,f,e,d,c,b,a}.
// Build option: SCROLL_DIR_EN (see scroll_sequencer.sv) needs nothing here.
package scroll_pkg;

  typedef enum logic {IDLE, RUN} scroll_state_t;

  localparam logic [6:0] BLANK_GLYPH = 7'h7F;

  localparam logic [6:0] GLYPH_0    = 7'h40;
  localparam logic [6:0] GLYPH_1    = 7'h79;
  localparam logic [6:0] GLYPH_2    = 7'h24;
  localparam logic [6:0] GLYPH_3    = 7'h30;
  localparam logic [6:0] GLYPH_4    = 7'h19;
  localparam logic [6:0] GLYPH_5    = 7'h12;
  localparam logic [6:0] GLYPH_6    = 7'h02;
  localparam logic [6:0] GLYPH_7    = 7'h78;
  localparam logic [6:0] GLYPH_8    = 7'h00;
  localparam logic [6:0] GLYPH_9    = 7'h10;
  localparam logic [6:0] GLYPH_A    = 7'h08;
  localparam logic [6:0] GLYPH_B    = 7'h03;
  localparam logic [6:0] GLYPH_C    = 7'h46;
  localparam logic [6:0] GLYPH_D    = 7'h21;
  localparam logic [6:0] GLYPH_E    = 7'h06;
  localparam logic [6:0] GLYPH_F    = 7'h0E;
  localparam logic [6:0] GLYPH_H    = 7'h09;
  localparam logic [6:0] GLYPH_L    = 7'h47;
  localparam logic [6:0] GLYPH_P    = 7'h0C;
  localparam logic [6:0] GLYPH_U    = 7'h41;
  localparam logic [6:0] GLYPH_DASH = 7'h3F;

endpackage

// File: rtl/scroll_sequencer_if.sv
// scroll_sequencer_if: control/write bus and display outputs of the scroll
// sequencer.
//   master : drives wr_en/wr_addr/wr_data, msg_len, start, stop;
//            receives next_hex0..5, hex_en, busy.
//   slave  : the sequencer side (inverse directions).
interface scroll_sequencer_if #(
  parameter int MSG_DEPTH = 16
);
  localparam int AW = $clog2(MSG_DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;
  logic [AW:0]   msg_len;
  logic          start;
  logic          stop;
  logic [6:0]    next_hex0, next_hex1, next_hex2;
  logic [6:0]    next_hex3, next_hex4, next_hex5;
  logic          hex_en;
  logic          busy;

  modport master (
    output wr_en, wr_addr, wr_data, msg_len, start, stop,
    input  next_hex0, next_hex1, next_hex2, next_hex3, next_hex4, next_hex5,
    input  hex_en, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, msg_len, start, stop,
    output next_hex0, next_hex1, next_hex2, next_hex3, next_hex4, next_hex5,
    output hex_en, busy
  );
endinterface

// File: rtl/scroll_sequencer_tick_divider.sv
// tick_divider: free-running step timer for the scroll sequencer.
// Ports: clk, reset (async, active-low), clr (hold count at 0),
//        tick (high while the count sits at TICK_DIV-1).
module tick_divider #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr || cnt_q == TC) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == TC);
endmodule

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: owns the glyph message buffer and slides a 6-digit
// window across it, pulsing hex_en once per window update.
// Ports: clk, reset (async, active-low), bus (scroll_sequencer_if.slave),
//        dir (only with SCROLL_DIR_EN: 0 = scroll left, 1 = scroll right).
// Build option: define SCROLL_DIR_EN to add the dir input.
module scroll_sequencer
  import scroll_pkg::*;
#(
  parameter int MSG_DEPTH = 16,
  parameter int TICK_DIV  = 25_000_000
) (
  input  logic clk,
  input  logic reset,
`ifdef SCROLL_DIR_EN
  input  logic dir,
`endif
  scroll_sequencer_if.slave bus
);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;

  scroll_state_t state_q;
  logic [AW-1:0] ptr_q;
  logic [LW-1:0] len_q;
  logic [6:0]    mem_q [MSG_DEPTH];
  logic [6:0]    hex_q [6];
  logic          hex_en_q;
  logic          busy_q;

  logic tick;
  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != RUN),
    .tick  (tick)
  );

  logic start_ok;
  assign start_ok = bus.start && !bus.stop && (bus.msg_len != '0) &&
                    (bus.msg_len <= LW'(MSG_DEPTH));

  logic [AW-1:0] ptr_d;
  always_comb begin
    ptr_d = (LW'(ptr_q) + LW'(1) == len_q) ? '0 : ptr_q + AW'(1);
`ifdef SCROLL_DIR_EN
    if (dir) ptr_d = (ptr_q == '0) ? AW'(len_q - LW'(1)) : ptr_q - AW'(1);
`endif
  end

  // A start loads the window from entry 0 using the incoming length, since
  // len_q is only latched on that same edge.
  logic          load;
  logic [AW-1:0] base;
  logic [LW-1:0] wlen;
  always_comb begin
    load = 1'b0;
    base = ptr_d;
    wlen = len_q;
    if (state_q == IDLE) begin
      base = '0;
      wlen = bus.msg_len;
      load = start_ok;
    end else begin
      load = tick && !bus.stop;
    end
  end

  // win[0] is the leftmost digit (HEX5); indices wrap at wlen without modulo.
  logic [6:0]    win [6];
  logic [LW-1:0] idx;
  always_comb begin
    idx = LW'(base);
    for (int k = 0; k < 6; k++) begin
      win[k] = mem_q[idx[AW-1:0]];
      idx    = (idx + LW'(1) == wlen) ? '0 : idx + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      len_q    <= '0;
      hex_en_q <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < MSG_DEPTH; i++) mem_q[i] <= BLANK_GLYPH;
      for (int k = 0; k < 6; k++) hex_q[k] <= BLANK_GLYPH;
    end else begin
      hex_en_q <= 1'b0;
      if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
      case (state_q)
        IDLE: if (start_ok) begin
          state_q <= RUN;
          len_q   <= bus.msg_len;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
        RUN: if (bus.stop) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (tick) begin
          ptr_q <= ptr_d;
        end
        default: state_q <= IDLE;
      endcase
      if (load) begin
        for (int k = 0; k < 6; k++) hex_q[k] <= win[k];
        hex_en_q <= 1'b1;
      end
    end
  end

  assign bus.next_hex5 = hex_q[0];
  assign bus.next_hex4 = hex_q[1];
  assign bus.next_hex3 = hex_q[2];
  assign bus.next_hex2 = hex_q[3];
  assign bus.next_hex1 = hex_q[4];
  assign bus.next_hex0 = hex_q[5];
  assign bus.hex_en    = hex_en_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: directed bench for scroll_sequencer with
// TICK_DIV=4, MSG_DEPTH=16. Honours SCROLL_DIR_EN when defined.
module tb_scroll_sequencer;
  localparam int MSG_DEPTH = 16;
  localparam int TICK_DIV  = 4;

  logic clk = 1'b0;
  logic reset;
`ifdef SCROLL_DIR_EN
  logic dir = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  scroll_sequencer_if #(.MSG_DEPTH(MSG_DEPTH)) sif ();

  scroll_sequencer #(.MSG_DEPTH(MSG_DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SCROLL_DIR_EN
    .dir   (dir),
`endif
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] dg [8];
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] GH = 7'h09;
  localparam logic [6:0] GE = 7'h06;
  localparam logic [6:0] GL = 7'h47;
  localparam logic [6:0] GD = 7'h3F;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [6:0] e5, e4, e3, e2, e1, e0,
                     input logic en, input logic bz);
    logic [43:0] obs, exp;
    obs = {sif.next_hex5, sif.next_hex4, sif.next_hex3, sif.next_hex2,
           sif.next_hex1, sif.next_hex0, sif.hex_en, sif.busy};
    exp = {e5, e4, e3, e2, e1, e0, en, bz};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [6:0] d);
    sif.wr_en   = 1'b1;
    sif.wr_addr = 4'(a);
    sif.wr_data = d;
    step(1);
    sif.wr_en   = 1'b0;
  endtask

  task automatic start_len(input int len);
    sif.msg_len = 5'(len);
    sif.start   = 1'b1;
    step(1);
    sif.start   = 1'b0;
  endtask

  initial begin
    dg[0] = 7'h40; dg[1] = 7'h79; dg[2] = 7'h24; dg[3] = 7'h30;
    dg[4] = 7'h19; dg[5] = 7'h12; dg[6] = 7'h02; dg[7] = 7'h78;
    reset = 1'b0;
    sif.wr_en = 1'b0; sif.wr_addr = '0; sif.wr_data = '0;
    sif.msg_len = '0; sif.start = 1'b0; sif.stop = 1'b0;

    // reset
    step(2);
    chk("reset_during", BL, BL, BL, BL, BL, BL, 1'b0, 1'b0);
    reset = 1'b1;
    step(2);
    chk("reset_after", BL, BL, BL, BL, BL, BL, 1'b0, 1'b0);

    // basic scroll, len 8
    for (int i = 0; i < 8; i++) wr(i, dg[i]);
    start_len(8);
    chk("start_win", dg[0], dg[1], dg[2], dg[3], dg[4], dg[5], 1'b1, 1'b1);
    step(3);
    chk("between_ticks", dg[0], dg[1], dg[2], dg[3], dg[4], dg[5], 1'b0, 1'b1);
    step(1);
    chk("shift1", dg[1], dg[2], dg[3], dg[4], dg[5], dg[6], 1'b1, 1'b1);
    step(1);
    chk("shift1_pulse_end", dg[1], dg[2], dg[3], dg[4], dg[5], dg[6], 1'b0, 1'b1);
    step(7);
    chk("shift3", dg[3], dg[4], dg[5], dg[6], dg[7], dg[0], 1'b1, 1'b1);
    step(20);
    chk("shift8_wrap", dg[0], dg[1], dg[2], dg[3], dg[4], dg[5], 1'b1, 1'b1);
    step(4);
    chk("shift9", dg[1], dg[2], dg[3], dg[4], dg[5], dg[6], 1'b1, 1'b1);

    // stop on the tick cycle freezes the display
    step(3);
    sif.stop = 1'b1;
    step(1);
    sif.stop = 1'b0;
    chk("stop_on_tick", dg[1], dg[2], dg[3], dg[4], dg[5], dg[6], 1'b0, 1'b0);
    step(8);
    chk("stopped_frozen", dg[1], dg[2], dg[3], dg[4], dg[5], dg[6], 1'b0, 1'b0);

    // start+stop together in IDLE, invalid lengths
    sif.stop = 1'b1;
    start_len(8);
    sif.stop = 1'b0;
    chk("start_with_stop", dg[1], dg[2], dg[3], dg[4], dg[5], dg[6], 1'b0, 1'b0);
    start_len(0);
    chk("len0_ignored", dg[1], dg[2], dg[3], dg[4], dg[5], dg[6], 1'b0, 1'b0);
    start_len(17);
    chk("len17_ignored", dg[1], dg[2], dg[3], dg[4], dg[5], dg[6], 1'b0, 1'b0);

    // restart begins at entry 0
    start_len(8);
    chk("restart_entry0", dg[0], dg[1], dg[2], dg[3], dg[4], dg[5], 1'b1, 1'b1);
    sif.stop = 1'b1;
    step(1);
    sif.stop = 1'b0;

    // short message, len 3, with writes during RUN
    wr(0, GH); wr(1, GE); wr(2, GL);
    start_len(3);
    chk("short_start", GH, GE, GL, GH, GE, GL, 1'b1, 1'b1);
    step(4);
    chk("short_shift1", GE, GL, GH, GE, GL, GH, 1'b1, 1'b1);
    step(3);
    wr(0, GD);
    chk("write_same_cycle_hidden", GL, GH, GE, GL, GH, GE, 1'b1, 1'b1);
    step(4);
    chk("write_visible_next", GD, GE, GL, GD, GE, GL, 1'b1, 1'b1);

    // asynchronous reset mid-RUN
    step(2);
    reset = 1'b0;
    #1;
    chk("reset_mid_run", BL, BL, BL, BL, BL, BL, 1'b0, 1'b0);
    step(1);
    reset = 1'b1;
    step(1);
    start_len(8);
    chk("buffer_cleared", BL, BL, BL, BL, BL, BL, 1'b1, 1'b1);
    sif.stop = 1'b1;
    step(1);
    sif.stop = 1'b0;

`ifdef SCROLL_DIR_EN
    for (int i = 0; i < 8; i++) wr(i, dg[i]);
    dir = 1'b0;
    start_len(8);
    step(3);
    dir = 1'b1;
    step(1);
    chk("dir_right", dg[7], dg[0], dg[1], dg[2], dg[3], dg[4], 1'b1, 1'b1);
    step(4);
    chk("dir_right2", dg[6], dg[7], dg[0], dg[1], dg[2], dg[3], 1'b1, 1'b1);
    dir = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
